// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths and the
// transfer-phase encoding used by APB masters on this bus.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at
// or after i_ptr, wrapping. Ports: i_req, i_ptr -> o_grant, o_index.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_index
);

  logic [IW-1:0] w_lo;
  logic [IW-1:0] w_hi;
  logic          w_any;
  logic          w_hi_ok;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    w_lo    = '0;
    w_hi    = '0;
    w_any   = 1'b0;
    w_hi_ok = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo  = IW'(i);
        w_any = 1'b1;
        if (IW'(i) >= i_ptr) begin
          w_hi    = IW'(i);
          w_hi_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_index = w_hi_ok ? w_hi : w_lo;
    o_grant = '0;
    if (w_any) o_grant = NUM_REQ'(1) << o_index;
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NUM_REQ requesters:
// round-robin grant, APB sequencing, pready timeout to error.
// Ports: req_* in / resp_*, grant, timeout_o out / APB master.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          resp_err,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          timeout_o,
  output logic                          pselx,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic                          pready,
  input  logic                          pslverr,
  input  logic [DATA_WIDTH-1:0]         prdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  apb_state_t r_state, w_state;

  logic [IW-1:0]         r_ptr, w_ptr;
  logic [IW-1:0]         r_idx, w_idx;
  logic [CW-1:0]         r_wait, w_wait;
  logic [NUM_REQ-1:0]    r_grant, w_grant;
  logic                  r_psel, w_psel;
  logic                  r_pen, w_pen;
  logic                  r_pwrite, w_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata;
  logic [NUM_REQ-1:0]    r_rvalid, w_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
  logic                  r_rerr, w_rerr;
  logic                  r_tmo, w_tmo_o;

  logic [NUM_REQ-1:0]    w_req_m;
  logic [NUM_REQ-1:0]    w_arb_grant;
  logic [IW-1:0]         w_arb_idx;
  logic                  w_tmo;
  logic                  w_exit;
  logic [IW-1:0]         w_ptr_inc;

  // The requester being answered this cycle may not win again.
  assign w_req_m = req_valid & ~r_rvalid;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .i_req   (w_req_m),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_index (w_arb_idx)
  );

  assign w_tmo  = (r_state == ACCESS) &&
                  (r_wait == CW'(TIMEOUT - 1));
  assign w_exit = (r_state == ACCESS) && (w_tmo || pready);

  assign w_ptr_inc = (r_idx == IW'(NUM_REQ - 1)) ?
                     '0 : r_idx + IW'(1);

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_idx    <= '0;
      r_wait   <= '0;
      r_grant  <= '0;
      r_psel   <= 1'b0;
      r_pen    <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_ptr    <= w_ptr;
      r_idx    <= w_idx;
      r_wait   <= w_wait;
      r_grant  <= w_grant;
      r_psel   <= w_psel;
      r_pen    <= w_pen;
      r_pwrite <= w_pwrite;
      r_paddr  <= w_paddr;
      r_pwdata <= w_pwdata;
      r_rvalid <= w_rvalid;
      r_rdata  <= w_rdata;
      r_rerr   <= w_rerr;
      r_tmo    <= w_tmo_o;
    end
  end

  always_comb begin
    w_state = r_state;
    unique case (r_state)
      IDLE:    if (|w_req_m) w_state = SETUP;
      SETUP:   w_state = ACCESS;
      ACCESS:  if (w_exit) w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_comb begin
    w_ptr    = r_ptr;
    w_idx    = r_idx;
    w_wait   = r_wait;
    w_grant  = r_grant;
    w_psel   = r_psel;
    w_pen    = r_pen;
    w_pwrite = r_pwrite;
    w_paddr  = r_paddr;
    w_pwdata = r_pwdata;
    w_rvalid = '0;
    w_rdata  = r_rdata;
    w_rerr   = r_rerr;
    w_tmo_o  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|w_req_m) begin
          w_idx    = w_arb_idx;
          w_grant  = w_arb_grant;
          w_psel   = 1'b1;
          w_pwrite = req_write[w_arb_idx];
          w_paddr  = req_addr[int'(w_arb_idx)*ADDR_WIDTH +:
                              ADDR_WIDTH];
          w_pwdata = req_wdata[int'(w_arb_idx)*DATA_WIDTH +:
                               DATA_WIDTH];
        end
      end
      SETUP: begin
        w_pen  = 1'b1;
        w_wait = '0;
      end
      ACCESS: begin
        if (w_exit) begin
          w_rvalid = r_grant;
          w_grant  = '0;
          w_psel   = 1'b0;
          w_pen    = 1'b0;
          w_ptr    = w_ptr_inc;
        end
        // Timeout wins over a pready arriving on the limit cycle.
        if (w_tmo) begin
          w_rdata = '0;
          w_rerr  = 1'b1;
          w_tmo_o = 1'b1;
        end else if (pready) begin
          w_rdata = r_pwrite ? '0 : prdata;
          w_rerr  = pslverr;
        end else begin
          w_wait = r_wait + CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign resp_valid = r_rvalid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_rerr;
  assign grant      = r_grant;
  assign timeout_o  = r_tmo;
  assign pselx      = r_psel;
  assign penable    = r_pen;
  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: hand-computed
// expectations for grant order, APB phases, timeout and reset.
module tb_apb_master_arbiter;

  logic         pclk = 1'b0;
  logic         preset;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_err;
  logic [3:0]   grant;
  logic         timeout_o;
  logic         pselx;
  logic         penable;
  logic         pwrite;
  logic [31:0]  paddr;
  logic [31:0]  pwdata;
  logic         pready;
  logic         pslverr;
  logic [31:0]  prdata;

  int n_checks = 0;
  int n_errors = 0;

  apb_master_arbiter dut (
    .pclk       (pclk),
    .preset     (preset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .grant      (grant),
    .timeout_o  (timeout_o),
    .pselx      (pselx),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .prdata     (prdata)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    preset    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b1;
    pslverr   = 1'b0;
    prdata    = '0;
    tick();
    tick();
    chk("rst_psel", 64'(pselx), 64'd0);
    chk("rst_pen", 64'(penable), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_paddr", 64'(paddr), 64'd0);
    preset = 1'b0;

    // single write from requester 0
    req_valid[0]       = 1'b1;
    req_write[0]       = 1'b1;
    req_addr[0 +: 32]  = 32'h10;
    req_wdata[0 +: 32] = 32'hA5A5;
    tick();
    chk("w_psel", 64'(pselx), 64'd1);
    chk("w_pen_setup", 64'(penable), 64'd0);
    chk("w_grant", 64'(grant), 64'h1);
    chk("w_paddr", 64'(paddr), 64'h10);
    chk("w_pwdata", 64'(pwdata), 64'hA5A5);
    chk("w_pwrite", 64'(pwrite), 64'd1);
    tick();
    chk("w_pen", 64'(penable), 64'd1);
    chk("w_psel_acc", 64'(pselx), 64'd1);
    tick();
    chk("w_rvalid", 64'(resp_valid), 64'h1);
    chk("w_rerr", 64'(resp_err), 64'd0);
    chk("w_rdata", 64'(resp_rdata), 64'd0);
    chk("w_psel_end", 64'(pselx), 64'd0);
    chk("w_grant_end", 64'(grant), 64'd0);
    tick();
    chk("w_mask", 64'(pselx), 64'd0);
    chk("w_pulse", 64'(resp_valid), 64'd0);
    req_valid = '0;

    // read from requester 2 with three wait states
    pready              = 1'b0;
    req_valid[2]        = 1'b1;
    req_write[2]        = 1'b0;
    req_addr[64 +: 32]  = 32'h20;
    tick();
    chk("r_grant", 64'(grant), 64'h4);
    chk("r_paddr", 64'(paddr), 64'h20);
    chk("r_pwrite", 64'(pwrite), 64'd0);
    tick();
    chk("r_pen", 64'(penable), 64'd1);
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_ws_paddr", 64'(paddr), 64'h20);
      chk("r_ws_psel", 64'(pselx), 64'd1);
      chk("r_ws_rvalid", 64'(resp_valid), 64'd0);
    end
    pready = 1'b1;
    prdata = 32'hDEAD;
    tick();
    chk("r_rvalid", 64'(resp_valid), 64'h4);
    chk("r_rdata", 64'(resp_rdata), 64'hDEAD);
    chk("r_rerr", 64'(resp_err), 64'd0);

    // timeout from requester 3; pready on the limit cycle is ignored
    pready             = 1'b0;
    req_valid[3]       = 1'b1;
    req_write[3]       = 1'b0;
    req_addr[96 +: 32] = 32'h30;
    tick();
    chk("t_grant", 64'(grant), 64'h8);
    tick();
    chk("t_pen", 64'(penable), 64'd1);
    req_valid = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t_wait_tmo", 64'(timeout_o), 64'd0);
      chk("t_wait_psel", 64'(pselx), 64'd1);
    end
    pready = 1'b1;
    prdata = 32'hBEEF;
    tick();
    chk("t_tmo", 64'(timeout_o), 64'd1);
    chk("t_rvalid", 64'(resp_valid), 64'h8);
    chk("t_rerr", 64'(resp_err), 64'd1);
    chk("t_rdata", 64'(resp_rdata), 64'd0);
    chk("t_psel", 64'(pselx), 64'd0);
    tick();
    chk("t_tmo_pulse", 64'(timeout_o), 64'd0);

    // all four requesting: order 0,1,2,3,0
    prdata = 32'h55;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = 32'h100 + 32'(i * 4);
      req_write[i]         = 1'b0;
    end
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_grant", 64'(grant), 64'(4'h1 << (k % 4)));
      chk("rr_paddr", 64'(paddr),
          64'(32'h100 + 32'((k % 4) * 4)));
      tick();
      tick();
      chk("rr_rvalid", 64'(resp_valid),
          64'(4'h1 << (k % 4)));
      chk("rr_rdata", 64'(resp_rdata), 64'h55);
    end
    req_valid = '0;

    // slave error on a write from requester 1
    pslverr            = 1'b1;
    req_valid[1]       = 1'b1;
    req_write[1]       = 1'b1;
    req_addr[32 +: 32] = 32'h44;
    req_wdata[32 +: 32] = 32'h1234;
    tick();
    chk("e_grant", 64'(grant), 64'h2);
    chk("e_pwdata", 64'(pwdata), 64'h1234);
    tick();
    tick();
    chk("e_rvalid", 64'(resp_valid), 64'h2);
    chk("e_rerr", 64'(resp_err), 64'd1);
    chk("e_rdata", 64'(resp_rdata), 64'd0);
    req_valid = '0;
    pslverr   = 1'b0;
    tick();
    req_valid = 4'hF;
    tick();
    chk("e_ptr2", 64'(grant), 64'h4);

    // reset during ACCESS aborts the transfer
    pready = 1'b0;
    tick();
    chk("x_pen", 64'(penable), 64'd1);
    preset = 1'b1;
    tick();
    chk("x_psel", 64'(pselx), 64'd0);
    chk("x_pen0", 64'(penable), 64'd0);
    chk("x_grant", 64'(grant), 64'd0);
    chk("x_rvalid", 64'(resp_valid), 64'd0);
    preset = 1'b0;
    tick();
    chk("x_regrant", 64'(grant), 64'h1);
    chk("x_psel1", 64'(pselx), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
